// File: rtl/divider_pkg.sv
// Shared divider definitions: FSM state encoding and default operand width.
// Caller FSMs that schedule around busy/done import this package as well.
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_LOAD = 3'd1,
    DIV_RUN  = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  // Edges from the accepting edge to the edge that raises done.
  function automatic int div_latency(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/iterative_divider_if.sv
// Request/result bundle between a caller FSM (master) and the iterative divider (slave).
interface iterative_divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/divider_step.sv
// One restoring division iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep or restore, and emit the quotient bit.
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  assign shifted = {rem_in, next_bit};
  // The extra top bit of trial is the borrow: set means the subtraction went negative.
  assign trial   = shifted - {2'b00, divisor};
  assign q_bit   = ~trial[WIDTH+1];
  assign rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];

endmodule

// File: rtl/iterative_divider.sv
// Fixed-latency restoring divider, one quotient bit per cycle.
// Define DIVIDER_SIGNED_EN for two's-complement (truncating) division; default is unsigned.
module iterative_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic srst,
  iterative_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [2:0] IDLE = DIV_IDLE;
  localparam logic [2:0] LOAD = DIV_LOAD;
  localparam logic [2:0] RUN  = DIV_RUN;
  localparam logic [2:0] FIX  = DIV_FIX;
  localparam logic [2:0] DONE = DIV_DONE;

  logic [2:0]       state_reg, state_next;
  logic             accept;

  logic [WIDTH-1:0] dvd_in_reg, dvs_in_reg;
  logic [WIDTH-1:0] dvd_sh_reg, dvs_mag_reg, q_reg;
  logic [WIDTH:0]   rem_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   rem_step;
  logic             q_bit;

  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             dbz_reg;

  assign accept = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD;
      LOAD:    state_next = RUN;
      RUN:     if (cnt_reg == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = bus.start ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef DIVIDER_SIGNED_EN
  logic dvd_neg, dvs_neg;

  // Operand signs live in the captured operands' MSBs for the whole operation.
  assign dvd_neg = dvd_in_reg[WIDTH-1];
  assign dvs_neg = dvs_in_reg[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dvd_in_reg : dvd_in_reg;
  assign dvs_mag = dvs_neg ? -dvs_in_reg : dvs_in_reg;
  // Truncating division: quotient sign from the sign mismatch, remainder follows the dividend.
  // The most-negative / -1 case falls out naturally: magnitude 2^(WIDTH-1) is the most-negative pattern.
  assign q_fix   = (dvd_neg ^ dvs_neg) ? -q_reg : q_reg;
  assign r_fix   = dvd_neg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
`else
  assign dvd_mag = dvd_in_reg;
  assign dvs_mag = dvs_in_reg;
  assign q_fix   = q_reg;
  assign r_fix   = rem_reg[WIDTH-1:0];
`endif

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in   (rem_reg),
    .divisor  (dvs_mag_reg),
    .next_bit (dvd_sh_reg[WIDTH-1]),
    .rem_out  (rem_step),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg   <= IDLE;
      dvd_in_reg  <= '0;
      dvs_in_reg  <= '0;
      dvd_sh_reg  <= '0;
      dvs_mag_reg <= '0;
      q_reg       <= '0;
      rem_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            dvd_in_reg <= bus.dividend;
            dvs_in_reg <= bus.divisor;
            rem_reg    <= '0;
            cnt_reg    <= CNT_LAST;
          end
        end
        LOAD: begin
          dvd_sh_reg  <= dvd_mag;
          dvs_mag_reg <= dvs_mag;
          q_reg       <= '0;
        end
        RUN: begin
          rem_reg    <= rem_step;
          dvd_sh_reg <= {dvd_sh_reg[WIDTH-2:0], 1'b0};
          q_reg      <= {q_reg[WIDTH-2:0], q_bit};
          if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Results move only on the FIX->DONE edge so they stay stable for the caller.
  always_ff @(posedge clk) begin
    if (srst) begin
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (state_reg == FIX) begin
      if (dvs_in_reg == '0) begin
        quotient_reg  <= '1;
        remainder_reg <= dvd_in_reg;
        dbz_reg       <= 1'b1;
      end else begin
        quotient_reg  <= q_fix;
        remainder_reg <= r_fix;
        dbz_reg       <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state_reg == LOAD) || (state_reg == RUN) || (state_reg == FIX);
  assign bus.done        = (state_reg == DONE);
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule
